// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   rw_type encodings (equal to funct3), FSM state type, byte-enable patterns.
package lsu_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Byte-enable patterns for lane 0; shifted into place by the address offset.
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
//   i_rw_type  : access width/sign (funct3)
//   i_addr_lo  : address bits [1:0]
//   i_we       : access is a store (unsigned widths are illegal for stores)
//   i_wdata    : store data from the register file
//   i_rdata    : word returned by the bus
//   o_be       : byte enables for the word-aligned bus access
//   o_wdata    : store data replicated across all lanes of its width
//   o_rdata    : selected lane, sign- or zero-extended
//   o_misalign : halfword not on an even address, or word not on a word address
//   o_illegal  : undefined width encoding, or unsigned width used by a store
module lsu_align (
  input  logic [2:0]  i_rw_type,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_illegal
);
  import lsu_pkg::*;

  // Addressed lane moved down to bit 0; only the low halfword is ever needed.
  logic [15:0] w_lane;
  assign w_lane = 16'(i_rdata >> {i_addr_lo, 3'b000});

  always_comb begin
    o_be       = BE_NONE;
    o_wdata    = '0;
    o_rdata    = '0;
    o_misalign = 1'b0;
    o_illegal  = 1'b0;
    case (i_rw_type)
      RW_B: begin
        o_be    = BE_BYTE << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
      end
      RW_BU: begin
        o_be      = BE_BYTE << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
        o_rdata   = {24'b0, w_lane[7:0]};
        o_illegal = i_we;
      end
      RW_H: begin
        o_be       = BE_HALF << {i_addr_lo[1], 1'b0};
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{w_lane[15]}}, w_lane};
        o_misalign = i_addr_lo[0];
      end
      RW_HU: begin
        o_be       = BE_HALF << {i_addr_lo[1], 1'b0};
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {16'b0, w_lane};
        o_misalign = i_addr_lo[0];
        o_illegal  = i_we;
      end
      RW_W: begin
        o_be       = BE_WORD;
        o_wdata    = i_wdata;
        o_rdata    = i_rdata;
        o_misalign = |i_addr_lo;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: one decoded load/store -> one word-aligned bus transaction.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid            : execute stage presents a memory instruction
//   mem_read, memwrite   : decoded load / store
//   rw_type              : funct3 width/sign
//   addr, wdata          : effective address, store data
//   lsu_stall            : hold pipeline (accepting in IDLE, or waiting on bus)
//   lsu_done             : one-cycle pulse, lsu_rdata/lsu_err valid
//   lsu_rdata, lsu_err   : extended load result, fault flag
//   bus_req..bus_wdata   : registered bus request, held stable until ack
//   bus_ack, bus_rdata   : bus completion and read word
module lsu_mem_if #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              memwrite,
  input  logic [2:0]        rw_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);
  import lsu_pkg::*;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic [7:0]        r_cnt;
  logic [2:0]        r_type;
  logic [1:0]        r_addr_lo;
  logic              r_we;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_be;
  logic [31:0]       r_bus_wdata;

  logic              w_idle;
  logic              w_accept;
  logic              w_fault;
  logic              w_timeout;
  logic [2:0]        w_sel_type;
  logic [1:0]        w_sel_lo;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ext;
  logic              w_misalign;
  logic              w_illegal;

  assign w_idle    = (r_state == IDLE);
  assign w_accept  = req_valid & (mem_read | memwrite);
  assign w_fault   = (mem_read & memwrite) | w_illegal | w_misalign;
  assign w_timeout = (r_cnt == CNT_LAST);

  // One aligner serves both phases: live inputs while accepting in IDLE,
  // captured width/offset while extracting the load word in BUS.
  assign w_sel_type = w_idle ? rw_type   : r_type;
  assign w_sel_lo   = w_idle ? addr[1:0] : r_addr_lo;

  lsu_align u_align (
    .i_rw_type  (w_sel_type),
    .i_addr_lo  (w_sel_lo),
    .i_we       (memwrite),
    .i_wdata    (wdata),
    .i_rdata    (bus_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_ext),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    lsu_stall = 1'b0;
    lsu_done  = 1'b0;
    lsu_err   = 1'b0;
    lsu_rdata = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          lsu_stall = 1'b1;
          w_next    = w_fault ? DONE : BUS;
        end
      end
      BUS: begin
        lsu_stall = 1'b1;
        if (bus_ack || w_timeout) w_next = DONE;
      end
      DONE: begin
        lsu_done  = 1'b1;
        lsu_err   = r_err;
        lsu_rdata = (r_we || r_err) ? '0 : r_rdata;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_type      <= '0;
      r_addr_lo   <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_type    <= rw_type;
            r_addr_lo <= addr[1:0];
            r_we      <= memwrite;
            r_err     <= w_fault;
            r_rdata   <= '0;
            if (!w_fault) begin
              r_bus_req   <= 1'b1;
              r_bus_we    <= memwrite;
              r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
            end
          end
        end
        BUS: begin
          r_cnt <= r_cnt + 8'd1;
          // Ack in the final timeout cycle still completes without error.
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            r_rdata   <= w_ext;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: fixed vector table, hand sequences for reset and
// non-requests, and random transactions against an arithmetic reference model.
module tb_lsu_mem_if;
  import lsu_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        mem_read;
  logic        memwrite;
  logic [2:0]  rw_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        lsu_stall;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_if #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
    .memwrite(memwrite), .rw_type(rw_type), .addr(addr), .wdata(wdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdw;
    int          ack_at;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic vec_t mkv(input logic rd, input logic wr, input logic [2:0] t,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rdw, input int ack_at,
                               input logic fault, input logic [3:0] be,
                               input logic [31:0] ewd, input logic [31:0] erd,
                               input logic err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.t = t; v.a = a; v.wd = wd; v.rdw = rdw; v.ack_at = ack_at;
    v.e.fault = fault; v.e.be = be; v.e.wd = ewd; v.e.rdata = erd; v.e.err = err;
    return v;
  endfunction

  // Reference: access size in bytes, alignment by modulo, lanes by shifting.
  function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] t,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdw, input int ack_at);
    exp_t e;
    int size;
    bit sgn;
    int off;
    longint unsigned mask;
    longint unsigned v;
    size = 0; sgn = 0;
    case (t)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 0; end
      3'd4: begin size = 1; sgn = 0; end
      3'd5: begin size = 2; sgn = 0; end
      default: size = 0;
    endcase
    off = int'(a % 4);
    e.fault = (rd && wr) || (size == 0) || (wr && t[2]) || ((size != 0) && (off % size != 0));
    e.be = '0;
    e.wd = '0;
    v = 0;
    if (size != 0) begin
      e.be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wd[8*(i % size) +: 8];
      mask = (64'd1 << (8 * size)) - 1;
      v = (64'(rdw) >> (8 * off)) & mask;
      if (sgn && v[8*size-1]) v = v | ~mask;
    end
    e.err   = e.fault || (ack_at >= TO);
    e.rdata = (e.err || wr) ? 32'h0 : v[31:0];
    return e;
  endfunction

  task automatic run_txn(input string nm, input vec_t v);
    int bus_cyc;
    int n;
    bit done_seen;
    bus_cyc = v.e.fault ? 0 : ((v.ack_at < TO) ? v.ack_at + 1 : TO);
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = v.rd; memwrite = v.wr; rw_type = v.t;
    addr = v.a; wdata = v.wd; bus_ack = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    chk({nm, " c0 stall"}, lsu_stall, 1);
    chk({nm, " c0 bus_req"}, bus_req, 0);
    chk({nm, " c0 done"}, lsu_done, 0);
    n = 1;
    done_seen = 0;
    while (!done_seen && n <= TO + 3) begin
      @(posedge clk); #1;
      bus_ack   = ((n - 1) == v.ack_at);
      bus_rdata = bus_ack ? v.rdw : $urandom;
      @(negedge clk);
      if (n <= bus_cyc) begin
        chk($sformatf("%s c%0d bus_req", nm, n), bus_req, 1);
        chk($sformatf("%s c%0d stall", nm, n), lsu_stall, 1);
        chk($sformatf("%s c%0d done", nm, n), lsu_done, 0);
        chk($sformatf("%s c%0d bus_addr", nm, n), bus_addr, v.a & 32'hFFFF_FFFC);
        chk($sformatf("%s c%0d bus_we", nm, n), bus_we, v.wr);
        chk($sformatf("%s c%0d bus_be", nm, n), bus_be, v.e.be);
        if (v.wr) chk($sformatf("%s c%0d bus_wdata", nm, n), bus_wdata, v.e.wd);
      end else begin
        chk($sformatf("%s done c%0d", nm, n), lsu_done, 1);
        chk($sformatf("%s done stall", nm), lsu_stall, 0);
        chk($sformatf("%s done bus_req", nm), bus_req, 0);
        chk($sformatf("%s lsu_err", nm), lsu_err, v.e.err);
        chk($sformatf("%s lsu_rdata", nm), lsu_rdata, v.e.rdata);
        done_seen = 1;
      end
      n++;
    end
    // Back in IDLE: a stray ack must not start or finish anything.
    @(posedge clk); #1;
    req_valid = 1'b0; mem_read = 1'b0; memwrite = 1'b0; bus_ack = 1'b1;
    @(negedge clk);
    chk({nm, " idle done"}, lsu_done, 0);
    chk({nm, " idle stall"}, lsu_stall, 0);
    chk({nm, " idle bus_req"}, bus_req, 0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; memwrite = 1'b0;
    rw_type = '0; addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst stall", lsu_stall, 0);
    chk("rst done", lsu_done, 0);
    chk("rst err", lsu_err, 0);
    chk("rst rdata", lsu_rdata, 0);
    chk("rst bus_req", bus_req, 0);
    chk("rst bus_we", bus_we, 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_be", bus_be, 0);
    chk("rst bus_wdata", bus_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    //          rd wr type    addr          wdata         rdata         ack f  be       ewd           erd           err
    tbl.push_back(mkv(1, 0, RW_W,  32'h1000, 32'h0,        32'hDEADBEEF, 0,  0, 4'b1111, 32'h0,        32'hDEADBEEF, 0));
    tbl.push_back(mkv(1, 0, RW_B,  32'h1003, 32'h0,        32'h80FFFFFF, 0,  0, 4'b1000, 32'h0,        32'hFFFFFF80, 0));
    tbl.push_back(mkv(1, 0, RW_BU, 32'h1003, 32'h0,        32'h80FFFFFF, 0,  0, 4'b1000, 32'h0,        32'h00000080, 0));
    tbl.push_back(mkv(0, 1, RW_H,  32'h2002, 32'h1234ABCD, 32'h55555555, 2,  0, 4'b1100, 32'hABCDABCD, 32'h0,        0));
    tbl.push_back(mkv(1, 0, RW_W,  32'h1001, 32'h0,        32'h0,        0,  1, 4'b0000, 32'h0,        32'h0,        1));
    tbl.push_back(mkv(1, 0, 3'b011,32'h1000, 32'h0,        32'h0,        0,  1, 4'b0000, 32'h0,        32'h0,        1));
    tbl.push_back(mkv(1, 1, RW_W,  32'h1000, 32'h0,        32'h0,        0,  1, 4'b0000, 32'h0,        32'h0,        1));
    tbl.push_back(mkv(1, 0, RW_W,  32'h3000, 32'h0,        32'h0,        99, 0, 4'b1111, 32'h0,        32'h0,        1));
    tbl.push_back(mkv(1, 0, RW_W,  32'h3004, 32'h0,        32'h11223344, 15, 0, 4'b1111, 32'h0,        32'h11223344, 0));
    tbl.push_back(mkv(0, 1, RW_B,  32'h4001, 32'h000000A5, 32'h0,        1,  0, 4'b0010, 32'hA5A5A5A5, 32'h0,        0));
    tbl.push_back(mkv(1, 0, RW_H,  32'h5002, 32'h0,        32'h80017FFF, 0,  0, 4'b1100, 32'h0,        32'hFFFF8001, 0));
    tbl.push_back(mkv(1, 0, RW_HU, 32'h5000, 32'h0,        32'h8001FFFE, 0,  0, 4'b0011, 32'h0,        32'h0000FFFE, 0));
    tbl.push_back(mkv(0, 1, RW_BU, 32'h4000, 32'h12,       32'h0,        0,  1, 4'b0000, 32'h0,        32'h0,        1));
    tbl.push_back(mkv(1, 0, RW_H,  32'h5001, 32'h0,        32'h0,        0,  1, 4'b0000, 32'h0,        32'h0,        1));
    tbl.push_back(mkv(0, 1, RW_W,  32'h6000, 32'hCAFEF00D, 32'h0,        0,  0, 4'b1111, 32'hCAFEF00D, 32'h0,        0));
    tbl.push_back(mkv(1, 0, 3'b110,32'h6000, 32'h0,        32'h0,        0,  1, 4'b0000, 32'h0,        32'h0,        1));
    tbl.push_back(mkv(1, 0, 3'b111,32'h6000, 32'h0,        32'h0,        0,  1, 4'b0000, 32'h0,        32'h0,        1));

    for (int i = 0; i < tbl.size(); i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Valid cycle without a memory operation: no stall, nothing starts.
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = 1'b0; memwrite = 1'b0; rw_type = RW_W; addr = 32'h1000;
    @(negedge clk);
    chk("noreq stall", lsu_stall, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("noreq bus_req", bus_req, 0);
    chk("noreq done", lsu_done, 0);

    // Reset in the middle of a bus wait, with an ack arriving in the reset cycle.
    @(posedge clk); #1;
    req_valid = 1'b1; mem_read = 1'b1; memwrite = 1'b0; rw_type = RW_W; addr = 32'h7000;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("midrst bus_req before", bus_req, 1);
    @(posedge clk); #1;
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h0BAD0BAD;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk("midrst bus_req", bus_req, 0);
    chk("midrst stall", lsu_stall, 0);
    chk("midrst done", lsu_done, 0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("midrst later done", lsu_done, 0);
    chk("midrst later bus_req", bus_req, 0);
    run_txn("postrst", mkv(1, 0, RW_W, 32'h7000, 32'h0, 32'h13579BDF, 1,
                           0, 4'b1111, 32'h0, 32'h13579BDF, 0));

    // Random transactions against the reference model.
    for (int k = 0; k < 150; k++) begin
      int op;
      op     = $urandom_range(0, 9);
      v.rd   = (op <= 5);
      v.wr   = (op == 0) || (op >= 6);
      v.t    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: v.t = RW_B;
          1: v.t = RW_H;
          2: v.t = RW_W;
          3: v.t = RW_BU;
          default: v.t = RW_HU;
        endcase
      end
      v.a = $urandom;
      if ($urandom_range(0, 1) != 0) v.a[0] = 1'b0;
      if ($urandom_range(0, 1) != 0) v.a[1] = 1'b0;
      v.wd  = $urandom;
      v.rdw = $urandom;
      v.ack_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 3))
                                               : int'($urandom_range(0, 3));
      v.e = model(v.rd, v.wr, v.t, v.a, v.wd, v.rdw, v.ack_at);
      run_txn($sformatf("rnd%0d", k), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
